// File: rtl/auth_response_checker.sv
// Receive-side authentication checker: skips dummy phases and folds the auth
// beats into a rotate-XOR MISR. Flags a match or tampering at session end.
module auth_response_checker #(
  parameter int DATA_W      = 128,
  parameter int INIT_DUMMY  = 10,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              check_start,
  input  logic              check_abort,
  input  logic [15:0]       n_auth,
  input  logic [15:0]       l_scan,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_data,
  input  logic              resp_is_auth,
  input  logic [DATA_W-1:0] expected_sig,
  output logic [DATA_W-1:0] signature,
  output logic              check_busy,
  output logic              check_done,
  output logic              response_match,
  output logic              tampering_detected
);

  typedef enum logic [2:0] {
    IDLE,
    SKIP_INIT,
    SKIP_INTER,
    COLLECT,
    COMPARE,
    DONE
  } state_t;

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [15:0]       INIT_LAST = 16'(INIT_DUMMY - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [15:0]       n_auth_q;
  logic [15:0]       l_scan_q;
  logic [15:0]       beat_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  function automatic logic [DATA_W-1:0] misr_fold(input logic [DATA_W-1:0] sig,
                                                  input logic [DATA_W-1:0] beat);
    return {sig[DATA_W-2:0], sig[DATA_W-1]} ^ beat;
  endfunction

  assign check_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      n_auth_q           <= '0;
      l_scan_q           <= '0;
      beat_cnt           <= '0;
      idle_cnt           <= '0;
      signature          <= '0;
      check_done         <= 1'b0;
      response_match     <= 1'b0;
      tampering_detected <= 1'b0;
    end else begin
      check_done <= 1'b0;
      if (check_abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (check_start) begin
              n_auth_q           <= n_auth;
              l_scan_q           <= l_scan;
              signature          <= '0;
              beat_cnt           <= '0;
              idle_cnt           <= '0;
              response_match     <= 1'b0;
              tampering_detected <= 1'b0;
              if (l_scan == 16'd0) begin
                tampering_detected <= 1'b1;
                check_done         <= 1'b1;
                state              <= DONE;
              end else begin
                state <= SKIP_INIT;
              end
            end
          end

          SKIP_INIT, SKIP_INTER, COLLECT: begin
            if (resp_valid) begin
              idle_cnt <= '0;
              // A beat whose phase tag disagrees with the current phase is never folded.
              if (resp_is_auth != (state == COLLECT)) begin
                tampering_detected <= 1'b1;
                check_done         <= 1'b1;
                state              <= DONE;
              end else if (state == SKIP_INIT) begin
                if (beat_cnt == INIT_LAST) begin
                  beat_cnt <= '0;
                  state    <= (n_auth_q == 16'd0) ? COLLECT : SKIP_INTER;
                end else begin
                  beat_cnt <= beat_cnt + 16'd1;
                end
              end else if (state == SKIP_INTER) begin
                if (beat_cnt == n_auth_q - 16'd1) begin
                  beat_cnt <= '0;
                  state    <= COLLECT;
                end else begin
                  beat_cnt <= beat_cnt + 16'd1;
                end
              end else begin
                signature <= misr_fold(signature, resp_data);
                if (beat_cnt == l_scan_q - 16'd1) begin
                  beat_cnt <= '0;
                  state    <= COMPARE;
                end else begin
                  beat_cnt <= beat_cnt + 16'd1;
                end
              end
            end else if (idle_cnt == IDLE_LAST) begin
              tampering_detected <= 1'b1;
              check_done         <= 1'b1;
              state              <= DONE;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end

          COMPARE: begin
            if (signature == expected_sig) begin
              response_match <= 1'b1;
            end else begin
              tampering_detected <= 1'b1;
            end
            check_done <= 1'b1;
            state      <= DONE;
          end

          DONE: state <= IDLE;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_auth_response_checker.sv
// Directed bench for auth_response_checker: full sessions, tag errors,
// zero-length session, timeout, abort, reset and start-while-busy.
module tb_auth_response_checker;

  localparam int DATA_W      = 128;
  localparam int TIMEOUT_CYC = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              check_start = 1'b0;
  logic              check_abort = 1'b0;
  logic [15:0]       n_auth = '0;
  logic [15:0]       l_scan = '0;
  logic              resp_valid = 1'b0;
  logic [DATA_W-1:0] resp_data = '0;
  logic              resp_is_auth = 1'b0;
  logic [DATA_W-1:0] expected_sig = '0;
  logic [DATA_W-1:0] signature;
  logic              check_busy;
  logic              check_done;
  logic              response_match;
  logic              tampering_detected;

  int n_cmp = 0;
  int n_err = 0;

  auth_response_checker #(.DATA_W(DATA_W), .INIT_DUMMY(10), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .check_start(check_start), .check_abort(check_abort),
    .n_auth(n_auth), .l_scan(l_scan), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_is_auth(resp_is_auth), .expected_sig(expected_sig), .signature(signature),
    .check_busy(check_busy), .check_done(check_done), .response_match(response_match),
    .tampering_detected(tampering_detected)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [15:0] na, input logic [15:0] ls);
    n_auth      = na;
    l_scan      = ls;
    check_start = 1'b1;
    tick();
    check_start = 1'b0;
  endtask

  task automatic beat(input logic [DATA_W-1:0] d, input logic tag);
    resp_valid   = 1'b1;
    resp_data    = d;
    resp_is_auth = tag;
    tick();
    resp_valid   = 1'b0;
  endtask

  task automatic dummies(input int n);
    for (int i = 0; i < n; i++) beat(DATA_W'(32'hD000 + i), 1'b0);
  endtask

  task automatic check_flags(input string tag, input logic done, input logic match,
                             input logic tamper);
    check_eq({tag, "_done"}, DATA_W'(check_done), DATA_W'(done));
    check_eq({tag, "_match"}, DATA_W'(response_match), DATA_W'(match));
    check_eq({tag, "_tamper"}, DATA_W'(tampering_detected), DATA_W'(tamper));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    #23;
    check_eq("rst_sig", signature, '0);
    check_eq("rst_busy", DATA_W'(check_busy), '0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: n_auth=3, l_scan=2, beats 1,2 fold to zero
    expected_sig = '0;
    start_session(16'd3, 16'd2);
    check_eq("t1_busy", DATA_W'(check_busy), DATA_W'(1));
    dummies(13);
    beat(DATA_W'(1), 1'b1);
    beat(DATA_W'(2), 1'b1);
    check_flags("t1_cmp", 1'b0, 1'b0, 1'b0);
    tick();
    check_flags("t1_end", 1'b1, 1'b1, 1'b0);
    check_eq("t1_sig", signature, '0);
    tick();
    check_eq("t1_done_off", DATA_W'(check_done), '0);
    check_eq("t1_idle", DATA_W'(check_busy), '0);
    check_eq("t1_hold", DATA_W'(response_match), DATA_W'(1));

    // 2: MSB rotates into bit 0 -> signature 1, mismatch
    start_session(16'd3, 16'd2);
    check_eq("t2_clr", DATA_W'(response_match), '0);
    dummies(13);
    beat({1'b1, {(DATA_W-1){1'b0}}}, 1'b1);
    beat('0, 1'b1);
    tick();
    check_flags("t2", 1'b1, 1'b0, 1'b1);
    check_eq("t2_sig", signature, DATA_W'(1));
    tick();

    // 3: n_auth=0 goes straight to COLLECT; an auth beat in SKIP_INTER would flag
    expected_sig = DATA_W'(8'hA5);
    start_session(16'd0, 16'd1);
    dummies(10);
    beat(DATA_W'(8'hA5), 1'b1);
    tick();
    check_flags("t3", 1'b1, 1'b1, 1'b0);
    check_eq("t3_sig", signature, DATA_W'(8'hA5));
    tick();

    // 4: fifth init beat tagged auth
    start_session(16'd3, 16'd2);
    dummies(4);
    beat(DATA_W'(32'hFFFF), 1'b1);
    check_flags("t4", 1'b1, 1'b0, 1'b1);
    check_eq("t4_sig", signature, '0);
    tick();

    // 5a: zero-length session
    start_session(16'd5, 16'd0);
    check_flags("t5a", 1'b1, 1'b0, 1'b1);
    tick();

    // 5b: stall mid-COLLECT until timeout
    start_session(16'd0, 16'd2);
    dummies(10);
    beat(DATA_W'(3), 1'b1);
    cyc = 0;
    for (int i = 0; i < TIMEOUT_CYC + 200; i++) begin
      tick();
      cyc++;
      if (check_done) break;
    end
    check_eq("t5b_cycles", DATA_W'(cyc), DATA_W'(TIMEOUT_CYC));
    check_flags("t5b", 1'b1, 1'b0, 1'b1);
    tick();

    // 6a: abort in SKIP_INTER
    start_session(16'd3, 16'd2);
    dummies(11);
    check_abort = 1'b1;
    tick();
    check_abort = 1'b0;
    check_eq("t6a_busy", DATA_W'(check_busy), '0);
    check_flags("t6a", 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_eq("t6a_nodone", DATA_W'(check_done), '0);

    // 6b: reset mid-COLLECT
    start_session(16'd0, 16'd4);
    dummies(10);
    beat(DATA_W'(32'h1234), 1'b1);
    beat(DATA_W'(32'h55), 1'b1);
    check_eq("t6b_sig_pre", signature, DATA_W'(32'h2468 ^ 32'h55));
    rst_n = 1'b0;
    #1;
    check_eq("t6b_sig", signature, '0);
    check_eq("t6b_busy", DATA_W'(check_busy), '0);
    check_flags("t6b", 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();

    // 6c: start pulse during COLLECT is ignored
    expected_sig = DATA_W'(4);
    start_session(16'd0, 16'd3);
    dummies(10);
    beat(DATA_W'(1), 1'b1);
    check_start = 1'b1;
    beat(DATA_W'(2), 1'b1);
    check_start = 1'b0;
    beat(DATA_W'(4), 1'b1);
    tick();
    check_flags("t6c", 1'b1, 1'b1, 1'b0);
    check_eq("t6c_sig", signature, DATA_W'(4));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
